// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU op codes, flag bit positions, flag masks and the
//               issue-controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_MOV  = 4'd1,
        OP_CMP  = 4'd2,
        OP_TEST = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ADD  = 4'd6,
        OP_ADC  = 4'd7,
        OP_SUB  = 4'd8,
        OP_SBB  = 4'd9,
        OP_MUL  = 4'd10,
        OP_AND  = 4'd11,
        OP_OR   = 4'd12,
        OP_XOR  = 4'd13,
        OP_NOT  = 4'd14,
        OP_CLRF = 4'd15
    } alu_op_t;

    localparam int unsigned c_FLAG_ZERO     = 7;
    localparam int unsigned c_FLAG_SIGN     = 6;
    localparam int unsigned c_FLAG_CARRY    = 5;
    localparam int unsigned c_FLAG_OVERFLOW = 4;

    localparam logic [7:0] c_BIT_Z = 8'(1 << c_FLAG_ZERO);
    localparam logic [7:0] c_BIT_S = 8'(1 << c_FLAG_SIGN);
    localparam logic [7:0] c_BIT_C = 8'(1 << c_FLAG_CARRY);
    localparam logic [7:0] c_BIT_V = 8'(1 << c_FLAG_OVERFLOW);

    localparam logic [7:0] c_MASK_NONE = 8'h00;
    localparam logic [7:0] c_MASK_Z    = c_BIT_Z;
    localparam logic [7:0] c_MASK_ZS   = c_BIT_Z | c_BIT_S;
    localparam logic [7:0] c_MASK_ZSC  = c_BIT_Z | c_BIT_S | c_BIT_C;
    localparam logic [7:0] c_MASK_ZSCV = c_BIT_Z | c_BIT_S | c_BIT_C | c_BIT_V;

    // Low nibble of the architectural flags is reserved and reads as zero.
    localparam logic [7:0] c_FLAG_VALID = c_MASK_ZSCV;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl_if
// Description : Request, ALU-drive, response and flag signals of the issue
//               controller; slave = controller side, master = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if #(
    parameter int WORD_SIZE = 8,
    parameter int TAG_W     = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic [3:0]           req_op;
    logic [WORD_SIZE-1:0] req_a;
    logic [WORD_SIZE-1:0] req_b;
    logic [TAG_W-1:0]     req_tag;

    logic [3:0]           alu_mode;
    logic [WORD_SIZE-1:0] alu_a;
    logic [WORD_SIZE-1:0] alu_b;
    logic [WORD_SIZE-1:0] alu_result;
    logic [7:0]           alu_flags;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_data;
    logic                 rsp_we;
    logic [TAG_W-1:0]     rsp_tag;

    logic [7:0]           flags_q;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag,
        input  alu_result, alu_flags,
        input  rsp_ready,
        output req_ready,
        output alu_mode, alu_a, alu_b,
        output rsp_valid, rsp_data, rsp_we, rsp_tag,
        output flags_q
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag,
        output alu_result, alu_flags,
        output rsp_ready,
        input  req_ready,
        input  alu_mode, alu_a, alu_b,
        input  rsp_valid, rsp_data, rsp_we, rsp_tag,
        input  flags_q
    );
endinterface : alu_issue_ctrl_if
`default_nettype wire

// File: rtl/alu_flag_policy.sv
`default_nettype none
// ============================================================================
// Module      : alu_flag_policy
// Description : Per-op flag update mask and register-writeback qualifier.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_flag_policy
    import alu_pkg::*;
(
    input  alu_op_t    i_op,
    output logic [7:0] o_update_mask,
    output logic       o_writes_result
);

    always_comb begin
        o_update_mask   = c_MASK_NONE;
        o_writes_result = 1'b1;
        case (i_op)
            OP_CMP, OP_TEST: begin
                o_update_mask   = c_MASK_ZSCV;
                o_writes_result = 1'b0;
            end
            OP_ADD, OP_ADC, OP_SUB, OP_SBB,
            OP_AND, OP_OR,  OP_XOR: begin
                o_update_mask   = c_MASK_ZSCV;
            end
            OP_SHL:  o_update_mask = c_MASK_ZSC;
            OP_SHR:  o_update_mask = c_MASK_ZS;
            OP_MUL:  o_update_mask = c_MASK_Z;
            OP_MOV, OP_NOT: begin
                o_update_mask   = c_MASK_NONE;
            end
            // CLRF clears flags through its own path, not through the mask.
            OP_NOP, OP_CLRF: begin
                o_update_mask   = c_MASK_NONE;
                o_writes_result = 1'b0;
            end
            default: begin
                o_update_mask   = c_MASK_NONE;
                o_writes_result = 1'b0;
            end
        endcase
    end

endmodule : alu_flag_policy
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Sequential front end for the combinational ALU: accepts ops,
//               holds ALU inputs for a settle window, merges flags, responds.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WORD_SIZE     = 8,
    parameter int TAG_W         = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    alu_issue_ctrl_if.slave  bus
);

    localparam logic [3:0] c_SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t               r_state;
    state_t               w_next_state;

    alu_op_t              r_op;
    logic [3:0]           r_cnt;
    alu_op_t              r_alu_mode;
    logic [WORD_SIZE-1:0] r_alu_a;
    logic [WORD_SIZE-1:0] r_alu_b;
    logic [WORD_SIZE-1:0] r_rsp_data;
    logic                 r_rsp_we;
    logic [TAG_W-1:0]     r_rsp_tag;
    logic [7:0]           r_flags;

    alu_op_t              w_req_op;
    logic                 w_direct;
    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_rsp_fire;
    logic                 w_capture;
    logic [7:0]           w_mask;
    logic                 w_writes;
    logic [7:0]           w_flags_merged;

    assign w_req_op = alu_op_t'(bus.req_op);

    // NOP and CLRF never touch the ALU, so they skip the settle window.
    assign w_direct = (w_req_op == OP_NOP) || (w_req_op == OP_CLRF);

    // A response handshake frees the slot in the same cycle, allowing
    // back-to-back issue without an idle bubble.
    assign w_req_ready = !reset &&
                         ((r_state == ST_IDLE) ||
                          ((r_state == ST_RESP) && bus.rsp_ready));
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_rsp_fire  = (r_state == ST_RESP) && bus.rsp_ready;
    assign w_capture   = (r_state == ST_ISSUE) && (r_cnt == 4'd0);

    alu_flag_policy u_flag_policy (
        .i_op            (r_op),
        .o_update_mask   (w_mask),
        .o_writes_result (w_writes)
    );

    assign w_flags_merged = ((r_flags & ~w_mask) | (bus.alu_flags & w_mask))
                            & c_FLAG_VALID;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_direct ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_capture) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_rsp_fire) begin
                    if (w_accept) begin
                        w_next_state = w_direct ? ST_RESP : ST_ISSUE;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= OP_NOP;
            r_cnt      <= 4'd0;
            r_alu_mode <= OP_NOP;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_rsp_data <= '0;
            r_rsp_we   <= 1'b0;
            r_rsp_tag  <= '0;
            r_flags    <= 8'h00;
        end else begin
            if (w_accept) begin
                r_op      <= w_req_op;
                r_rsp_tag <= bus.req_tag;
                r_cnt     <= c_SETTLE_INIT;
                if (w_direct) begin
                    r_rsp_data <= '0;
                    r_rsp_we   <= 1'b0;
                    if (w_req_op == OP_CLRF) begin
                        r_flags <= 8'h00;
                    end
                end else begin
                    // The ALU drive registers double as the operand holding registers.
                    r_alu_mode <= w_req_op;
                    r_alu_a    <= bus.req_a;
                    r_alu_b    <= bus.req_b;
                end
            end

            if (r_state == ST_ISSUE) begin
                if (w_capture) begin
                    r_rsp_data <= w_writes ? bus.alu_result : '0;
                    r_rsp_we   <= w_writes;
                    r_flags    <= w_flags_merged;
                    r_alu_mode <= OP_NOP;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.alu_mode  = r_alu_mode;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_we    = r_rsp_we;
    assign bus.rsp_tag   = r_rsp_tag;
    assign bus.flags_q   = r_flags;

endmodule : alu_issue_ctrl
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench: directed scenarios plus randomized ops
//               against a behavioural model; second instance with settle 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WORD_SIZE(8), .TAG_W(3)) bus ();
    alu_issue_ctrl_if #(.WORD_SIZE(8), .TAG_W(3)) bus3 ();

    alu_issue_ctrl #(.WORD_SIZE(8), .TAG_W(3), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    alu_issue_ctrl #(.WORD_SIZE(8), .TAG_W(3), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3));

    // Environment ALU: returns {flags, result}
    function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        r = 8'h00;
        case (op)
            OP_MOV:                 r = b;
            OP_ADD, OP_ADC:         begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; end
            OP_SUB, OP_SBB, OP_CMP: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; end
            OP_AND, OP_TEST:        r = a & b;
            OP_OR:                  r = a | b;
            OP_XOR:                 r = a ^ b;
            OP_NOT:                 r = ~a;
            OP_SHL:                 begin w = {a, 1'b0}; r = w[7:0]; end
            OP_SHR:                 r = {1'b0, a[7:1]};
            OP_MUL:                 r = 8'(a * b);
            default:                r = 8'h00;
        endcase
        if (!(op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_CMP, OP_SHL})) w = {a[0], r};
        return {(r == 8'h00), r[7], w[8], a[7] ^ b[7] ^ r[7] ^ w[8], 4'b0000, r};
    endfunction

    function automatic logic [7:0] ref_mask(input logic [3:0] op);
        if (op inside {OP_CMP, OP_TEST, OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_AND, OP_OR, OP_XOR}) return 8'hF0;
        if (op == OP_SHL) return 8'hE0;
        if (op == OP_SHR) return 8'hC0;
        if (op == OP_MUL) return 8'h80;
        return 8'h00;
    endfunction

    function automatic logic ref_writes(input logic [3:0] op);
        return !(op inside {OP_NOP, OP_CMP, OP_TEST, OP_CLRF});
    endfunction

    logic        f_en;
    logic [7:0]  f_res, f_flags;
    logic [15:0] w_m1, w_m3;
    assign w_m1 = alu_model(bus.alu_mode, bus.alu_a, bus.alu_b);
    assign w_m3 = alu_model(bus3.alu_mode, bus3.alu_a, bus3.alu_b);
    assign bus.alu_result  = f_en ? f_res   : w_m1[7:0];
    assign bus.alu_flags   = f_en ? f_flags : w_m1[15:8];
    assign bus3.alu_result = w_m3[7:0];
    assign bus3.alu_flags  = w_m3[15:8];

    // Issues one op on the default instance and collects the response.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] tag, input int stall,
                         output int lat, output logic [7:0] d, output logic we, output logic [2:0] tg,
                         output logic [3:0] mode1, output logic [7:0] a1, output logic [7:0] b1,
                         output bit mode_seen, output bit unstable, output bit timeout);
        int w;
        lat = 0; d = 0; we = 0; tg = 0; mode1 = 0; a1 = 0; b1 = 0;
        mode_seen = 0; unstable = 0; timeout = 0;
        @(negedge clk);
        bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
        bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
        #1;
        w = 0;
        while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
        if (!bus.req_ready) begin timeout = 1; bus.req_valid = 1'b0; return; end
        @(posedge clk); #1 bus.req_valid = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin mode1 = bus.alu_mode; a1 = bus.alu_a; b1 = bus.alu_b; end
            if (bus.alu_mode != 4'd0) mode_seen = 1;
            if (bus.rsp_valid) break;
        end
        if (!bus.rsp_valid) begin timeout = 1; return; end
        d = bus.rsp_data; we = bus.rsp_we; tg = bus.rsp_tag;
        if (stall > 0) begin
            bus.rsp_ready = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                if (!bus.rsp_valid || bus.rsp_data !== d || bus.rsp_we !== we || bus.rsp_tag !== tg) unstable = 1;
            end
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    int lat; logic [7:0] d, a1, b1; logic we; logic [2:0] tg; logic [3:0] m1; bit ms, us, to;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
        checks++;
        if ({bus.rsp_valid, bus.rsp_we, bus.rsp_data, bus.rsp_tag, bus.flags_q, bus.alu_mode, bus.alu_a, bus.alu_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b we=%b d=%h t=%h f=%h m=%h a=%h b=%h expected all zero",
                     bus.rsp_valid, bus.rsp_we, bus.rsp_data, bus.rsp_tag, bus.flags_q, bus.alu_mode, bus.alu_a, bus.alu_b);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus3.req_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_ready: got %b/%b expected 1/1", bus.req_ready, bus3.req_ready);
        end
    endtask

    task automatic test_reset_mid_issue();
        f_en = 1'b1; f_res = 8'h11; f_flags = 8'hF0;
        issue(OP_ADD, 8'h01, 8'h02, 3'd1, 0, lat, d, we, tg, m1, a1, b1, ms, us, to);
        f_en = 1'b0;
        @(negedge clk);
        bus.req_op = OP_ADD; bus.req_a = 8'h03; bus.req_b = 8'h04; bus.req_tag = 3'd2; bus.req_valid = 1'b1;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        checks++;
        if (bus.alu_mode !== OP_ADD) begin errors++; $display("FAIL midrst_issue_mode: got %h expected %h", bus.alu_mode, OP_ADD); end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        ms = 0;
        repeat (5) begin @(negedge clk); if (bus.rsp_valid !== 1'b0) ms = 1; end
        checks++;
        if (ms) begin errors++; $display("FAIL midrst_rsp_valid: got 1 expected 0"); end
        checks++;
        if (bus.flags_q !== 8'h00 || bus.alu_mode !== 4'd0) begin
            errors++; $display("FAIL midrst_state: got flags=%h mode=%h expected 00/0", bus.flags_q, bus.alu_mode);
        end
    endtask

    task automatic test_add();
        f_en = 1'b1; f_res = 8'h00; f_flags = 8'hA0;
        issue(OP_ADD, 8'hFF, 8'h01, 3'd5, 0, lat, d, we, tg, m1, a1, b1, ms, us, to);
        checks++;
        if (to || lat != 2) begin errors++; $display("FAIL add_latency: got %0d (timeout=%0d) expected 2", lat, to); end
        checks++;
        if (d !== 8'h00 || we !== 1'b1 || tg !== 3'd5) begin
            errors++; $display("FAIL add_rsp: got d=%h we=%b tag=%0d expected 00/1/5", d, we, tg);
        end
        checks++;
        if (bus.flags_q !== 8'hA0) begin errors++; $display("FAIL add_flags: got %h expected a0", bus.flags_q); end
        checks++;
        if (m1 !== OP_ADD || a1 !== 8'hFF || b1 !== 8'h01) begin
            errors++; $display("FAIL add_alu_drive: got m=%h a=%h b=%h expected 6/ff/01", m1, a1, b1);
        end
    endtask

    task automatic test_flag_masks();
        logic [7:0] pre[4]   = '{8'h80, 8'h30, 8'hE0, 8'h70};
        logic [3:0] op[4]    = '{OP_CMP, OP_SHR, OP_SHR, OP_MUL};
        logic [7:0] af[4]    = '{8'h60, 8'hF0, 8'h10, 8'h80};
        logic [7:0] expf[4]  = '{8'h60, 8'hF0, 8'h20, 8'hF0};
        f_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_res = 8'h00; f_flags = pre[i];
            issue(OP_ADD, 8'h00, 8'h00, 3'd0, 0, lat, d, we, tg, m1, a1, b1, ms, us, to);
            f_res = 8'h77; f_flags = af[i];
            issue(op[i], 8'h10, 8'h20, 3'd3, 0, lat, d, we, tg, m1, a1, b1, ms, us, to);
            checks++;
            if (to || bus.flags_q !== expf[i]) begin
                errors++; $display("FAIL mask_flags[%0d]: got %h expected %h", i, bus.flags_q, expf[i]);
            end
            checks++;
            if (we !== ref_writes(op[i]) || d !== (ref_writes(op[i]) ? 8'h77 : 8'h00)) begin
                errors++; $display("FAIL mask_rsp[%0d]: got d=%h we=%b", i, d, we);
            end
        end
        issue(OP_CLRF, 8'h00, 8'h00, 3'd0, 0, lat, d, we, tg, m1, a1, b1, ms, us, to);
        f_res = 8'h00; f_flags = 8'h70;
        issue(OP_MUL, 8'h02, 8'h03, 3'd4, 0, lat, d, we, tg, m1, a1, b1, ms, us, to);
        checks++;
        if (bus.flags_q !== 8'h00) begin errors++; $display("FAIL mul_flags: got %h expected 00", bus.flags_q); end
    endtask

    task automatic test_clrf();
        f_en = 1'b1; f_res = 8'h00; f_flags = 8'hF0;
        issue(OP_ADD, 8'h00, 8'h00, 3'd0, 0, lat, d, we, tg, m1, a1, b1, ms, us, to);
        issue(OP_CLRF, 8'h5A, 8'hA5, 3'd6, 0, lat, d, we, tg, m1, a1, b1, ms, us, to);
        checks++;
        if (to || lat != 1 || ms) begin errors++; $display("FAIL clrf_timing: got lat=%0d mode_seen=%0d expected 1/0", lat, ms); end
        checks++;
        if (bus.flags_q !== 8'h00 || we !== 1'b0 || d !== 8'h00 || tg !== 3'd6) begin
            errors++; $display("FAIL clrf_rsp: got f=%h we=%b d=%h tag=%0d expected 00/0/00/6", bus.flags_q, we, d, tg);
        end
    endtask

    task automatic test_back_to_back();
        bit bad = 0;
        int n = 0;
        f_en = 1'b1; f_res = 8'h5A; f_flags = 8'h00;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_op = OP_MOV; bus.req_a = 8'h00; bus.req_b = 8'h5A; bus.req_tag = 3'd2; bus.req_valid = 1'b1;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
        f_res = 8'h33;
        repeat (4) begin
            if (!bus.rsp_valid || bus.rsp_data !== 8'h5A || bus.req_ready !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (n != 2 || bad) begin errors++; $display("FAIL b2b_hold: got lat=%0d unstable=%0d expected 2/0", n, bad); end
        bus.rsp_ready = 1'b1;
        bus.req_op = OP_ADD; bus.req_a = 8'h11; bus.req_b = 8'h22; bus.req_tag = 3'd7; bus.req_valid = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_data !== 8'h5A) begin
            errors++; $display("FAIL b2b_ready: got ready=%b d=%h expected 1/5a", bus.req_ready, bus.rsp_data);
        end
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.alu_mode !== OP_ADD) begin
            errors++; $display("FAIL b2b_issue: got v=%b mode=%h expected 0/6", bus.rsp_valid, bus.alu_mode);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h33 || bus.rsp_tag !== 3'd7) begin
            errors++; $display("FAIL b2b_second: got v=%b d=%h tag=%0d expected 1/33/7", bus.rsp_valid, bus.rsp_data, bus.rsp_tag);
        end
        @(posedge clk); #1;
        f_en = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] ref_flags, exp_d, a, b;
        logic [3:0] op;
        logic [2:0] tag;
        logic [15:0] m;
        int stall, exp_lat;
        f_en = 1'b0;
        issue(OP_CLRF, 8'h00, 8'h00, 3'd0, 0, lat, d, we, tg, m1, a1, b1, ms, us, to);
        ref_flags = 8'h00;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15)); a = 8'($urandom); b = 8'($urandom);
            tag = 3'($urandom); stall = $urandom_range(0, 3);
            m = alu_model(op, a, b);
            exp_d = ref_writes(op) ? m[7:0] : 8'h00;
            exp_lat = (op == OP_NOP || op == OP_CLRF) ? 1 : 2;
            if (op == OP_CLRF) ref_flags = 8'h00;
            else ref_flags = (ref_flags & ~ref_mask(op)) | (m[15:8] & ref_mask(op));
            issue(op, a, b, tag, stall, lat, d, we, tg, m1, a1, b1, ms, us, to);
            checks++;
            if (to || lat != exp_lat || us) begin
                errors++; $display("FAIL rand_timing[%0d] op=%0d: got lat=%0d to=%0d unstable=%0d expected lat=%0d", i, op, lat, to, us, exp_lat);
            end
            checks++;
            if (d !== exp_d || we !== ref_writes(op) || tg !== tag) begin
                errors++; $display("FAIL rand_rsp[%0d] op=%0d: got d=%h we=%b tag=%0d expected d=%h we=%b tag=%0d", i, op, d, we, tg, exp_d, ref_writes(op), tag);
            end
            checks++;
            if (bus.flags_q !== ref_flags) begin
                errors++; $display("FAIL rand_flags[%0d] op=%0d: got %h expected %h", i, op, bus.flags_q, ref_flags);
            end
            if (exp_lat == 2) begin
                checks++;
                if (m1 !== op || a1 !== a || b1 !== b) begin
                    errors++; $display("FAIL rand_drive[%0d]: got m=%h a=%h b=%h expected %h/%h/%h", i, m1, a1, b1, op, a, b);
                end
            end else begin
                checks++;
                if (ms) begin errors++; $display("FAIL rand_nop_mode[%0d]: got mode activity expected none", i); end
            end
        end
    endtask

    task automatic test_settle3();
        int n = 0, held = 0;
        logic [15:0] m;
        m = alu_model(OP_ADD, 8'h92, 8'h34);
        @(negedge clk);
        bus3.req_op = OP_ADD; bus3.req_a = 8'h92; bus3.req_b = 8'h34; bus3.req_tag = 3'd6; bus3.req_valid = 1'b1;
        #1;
        checks++;
        if (bus3.req_ready !== 1'b1) begin errors++; $display("FAIL s3_ready: got %b expected 1", bus3.req_ready); end
        @(posedge clk); #1 bus3.req_valid = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus3.alu_mode == OP_ADD) held++;
            if (bus3.rsp_valid) break;
        end
        checks++;
        if (n != 4 || held != 3) begin errors++; $display("FAIL s3_timing: got lat=%0d held=%0d expected 4/3", n, held); end
        checks++;
        if (bus3.rsp_data !== m[7:0] || bus3.rsp_we !== 1'b1 || bus3.rsp_tag !== 3'd6 || bus3.flags_q !== m[15:8]) begin
            errors++; $display("FAIL s3_rsp: got d=%h we=%b tag=%0d f=%h expected %h/1/6/%h",
                               bus3.rsp_data, bus3.rsp_we, bus3.rsp_tag, bus3.flags_q, m[7:0], m[15:8]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_a = 8'h00; bus.req_b = 8'h00; bus.req_tag = 3'd0;
        bus.rsp_ready = 1'b1;
        bus3.req_valid = 1'b0; bus3.req_op = 4'd0; bus3.req_a = 8'h00; bus3.req_b = 8'h00; bus3.req_tag = 3'd0;
        bus3.rsp_ready = 1'b1;
        f_en = 1'b0; f_res = 8'h00; f_flags = 8'h00;
        reset = 1'b1;
        test_reset();
        test_reset_mid_issue();
        test_add();
        test_flag_masks();
        test_clrf();
        test_back_to_back();
        test_random();
        test_settle3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule : tb_alu_issue_ctrl
`default_nettype wire
